bit_diff_gen: RTL
=================

BIT_DIFF_GEN -- requirements
Module: bit_diff_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning output word width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter DW, default $clog2(2*WIDTH+1), meaning width of the signed diff input.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  diff request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port diff  input  DW (signed)  target value of (ones - zeros).
REQ-008 SHALL have port out_valid  output  1  data/err valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port data  output  WIDTH  generated word.
REQ-011 SHALL have port err  output  1  request was unrealisable.

Function
REQ-012 SHALL generate data whose (count of 1 bits - count of 0 bits) equals diff: the inverse of bit_diff.
REQ-013 SHALL set bits [ones-1:0] and clear the rest, with ones = (WIDTH + diff) / 2.
REQ-014 SHALL compute WIDTH + diff in signed arithmetic at least DW+1 bits wide, with no truncation before the range check.
REQ-015 SHALL flag a request invalid if diff < -WIDTH, diff > WIDTH, or (WIDTH + diff) is odd.
REQ-016 SHALL implement FSM states IDLE, BUILD and HOLD.
REQ-017 SHALL drive in_ready = 1 only in IDLE, and register it.
REQ-018 In IDLE, on in_valid && in_ready, a valid request SHALL latch ones, clear count and the shift register, and go to BUILD.
REQ-019 In IDLE, on in_valid && in_ready, an invalid request SHALL go directly to HOLD with data = 0 and err = 1.
REQ-020 In BUILD, one bit per cycle: shift_r <= {(count_r < ones_r), shift_r[WIDTH-1:1]}, and count_r increments.
REQ-021 In BUILD, when count_r == WIDTH-1, the block SHALL load data from the final shift value, set err = 0, set out_valid = 1, and go to HOLD.
REQ-022 count_r SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap inside BUILD.
REQ-023 Latency for a valid request SHALL be: accepted at edge E, out_valid rises after edge E+WIDTH.
REQ-024 Latency for an invalid request SHALL be: out_valid rises after edge E+1.
REQ-025 In HOLD, data, err and out_valid SHALL stay stable while out_ready = 0, for any number of cycles.
REQ-026 In HOLD, on out_ready = 1, out_valid SHALL fall and in_ready SHALL rise on the same edge (return to IDLE).
REQ-027 There SHALL be no HOLD->BUILD bypass; minimum spacing is WIDTH+2 cycles per valid word.
REQ-028 in_valid and diff SHALL be ignored outside IDLE.
REQ-029 diff SHALL be sampled only at the accepting edge.
REQ-030 out_ready SHALL be ignored outside HOLD.
REQ-031 diff = +WIDTH SHALL give data all ones; diff = -WIDTH SHALL give data all zeros; both are valid (err = 0).

Reset
REQ-032 While rst_n = 0, the block SHALL force: state = IDLE, in_ready = 0, out_valid = 0, data = 0, err = 0, count_r = 0, shift_r = 0, ones_r = 0.
REQ-033 in_ready SHALL go to 1 on the first rising clk edge after rst_n deasserts.
REQ-034 Asserting rst_n mid-BUILD or mid-HOLD SHALL abort immediately; the partial word SHALL never be presented.

Verification
REQ-035 The bench SHALL cover, with WIDTH=32: diff=0 -> after 32 cycles data=0x0000FFFF, err=0.
REQ-036 The bench SHALL cover, with WIDTH=32: diff=+32 -> data=0xFFFFFFFF; diff=-32 -> data=0x00000000; both err=0.
REQ-037 The bench SHALL cover, with WIDTH=32: diff=+3 (odd) -> out_valid after 1 cycle, err=1, data=0; diff=-34 -> err=1.
REQ-038 The bench SHALL cover, with WIDTH=32: diff=-30, out_ready held 0 for 10 cycles -> data=0x00000001 stable, in_ready=0 throughout; then out_ready=1 -> in_ready=1 next cycle.
REQ-039 The bench SHALL cover, with WIDTH=32: rst_n pulsed low at BUILD cycle 15 -> out_valid never asserts for that request, in_ready=1 one edge after release.
REQ-040 The bench SHALL cover, with WIDTH=32: round trip of all even diff in -32..32 through bit_diff (WIDTH=32) -> its result equals diff every time.

Source files
------------

// File: rtl/bit_diff_gen.sv
// rtl/bit_diff_gen.sv - builds a WIDTH-bit word whose (ones - zeros) equals a signed target
module bit_diff_gen #(
  parameter int WIDTH = 32,
  parameter int DW    = $clog2(2*WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] diff,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     data,
  output logic                 err
);

  // Bit counter, ones-count and range-check arithmetic widths.
  // The sum carries two guard bits so WIDTH + diff never truncates.
  localparam int CW = $clog2(WIDTH);
  localparam int OW = $clog2(WIDTH+1);
  localparam int SW = DW + 2;

  localparam logic [CW-1:0]        LAST   = CW'(WIDTH-1);
  localparam logic signed [SW-1:0] W_S    = SW'(WIDTH);
  localparam logic signed [SW-1:0] W2_S   = SW'(2*WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_r, state_nx;
  logic [CW-1:0]    count_r, count_nx;
  logic [OW-1:0]    ones_r, ones_nx;
  logic [WIDTH-1:0] shift_r, shift_nx;
  logic [WIDTH-1:0] data_nx;
  logic             err_nx;
  logic             out_valid_nx;
  logic             in_ready_nx;

  // Request decode: sign-extend diff, form WIDTH + diff and classify it.
  logic signed [SW-1:0] diff_ext;
  logic signed [SW-1:0] sum;
  logic                 bad;
  logic [OW-1:0]        ones_req;

  assign diff_ext = {{2{diff[DW-1]}}, diff};
  assign sum      = W_S + diff_ext;
  // Negative sum means diff < -WIDTH; sum > 2*WIDTH means diff > WIDTH;
  // an odd sum cannot be split into an integer count of ones.
  assign bad      = sum[SW-1] || (sum > W2_S) || sum[0];
  assign ones_req = sum[OW:1];

  // One step of the serial builder: bit k of the result is (k < ones).
  logic [OW-1:0]    count_ext;
  logic             new_bit;
  logic [WIDTH-1:0] shift_step;

  assign count_ext  = OW'(count_r);
  assign new_bit    = (count_ext < ones_r);
  assign shift_step = {new_bit, shift_r[WIDTH-1:1]};

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      count_r   <= '0;
      ones_r    <= '0;
      shift_r   <= '0;
      data      <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state_r   <= state_nx;
      count_r   <= count_nx;
      ones_r    <= ones_nx;
      shift_r   <= shift_nx;
      data      <= data_nx;
      err       <= err_nx;
      out_valid <= out_valid_nx;
      in_ready  <= in_ready_nx;
    end
  end

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_nx     = state_r;
    count_nx     = count_r;
    ones_nx      = ones_r;
    shift_nx     = shift_r;
    data_nx      = data;
    err_nx       = err;
    out_valid_nx = out_valid;

    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (bad) begin
            // Unrealisable target: report immediately, no build phase.
            data_nx      = '0;
            err_nx       = 1'b1;
            out_valid_nx = 1'b1;
            state_nx     = HOLD;
          end else begin
            ones_nx  = ones_req;
            count_nx = '0;
            shift_nx = '0;
            state_nx = BUILD;
          end
        end
      end

      BUILD: begin
        shift_nx = shift_step;
        if (count_r == LAST) begin
          // Last bit shifted in: publish the completed word.
          data_nx      = shift_step;
          err_nx       = 1'b0;
          out_valid_nx = 1'b1;
          state_nx     = HOLD;
        end else begin
          count_nx = count_r + CW'(1);
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // in_ready is registered and tracks the state we are about to enter.
    in_ready_nx = (state_nx == IDLE);
  end

endmodule
